// File: rtl/bq_cascade.sv
// Cascade of N_STAGES direct-form-I biquads sharing one multiply-accumulate unit,
// programmed over Wishbone. Define BQ_CASCADE_ROUND_EN for round-half-up results (default: truncation).
module bq_cascade #(
  parameter int          DATA_W   = 16,
  parameter int          COEF_W   = 16,
  parameter int          FRAC_W   = 14,
  parameter int          N_STAGES = 2,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [DATA_W-1:0] x_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] y_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              sat_o
);

  localparam int ACC_W  = DATA_W + COEF_W + 3;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RES_W  = ACC_W - FRAC_W;
  localparam logic [2:0] LAST_STAGE = 3'(N_STAGES - 1);
  localparam logic [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC_W;

`ifdef BQ_CASCADE_ROUND_EN
  localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_W - 1);
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_OUT
  } state_t;

  state_t                   state;
  logic [2:0]               stage;
  logic [2:0]               kidx;
  logic                     stage_byp;
  logic signed [DATA_W-1:0] cur_x;
  logic signed [ACC_W-1:0]  acc;

  logic                     enable;
  logic [N_STAGES-1:0]      bypass;

  // Coefficient order within a stage: b0, b1, b2, a1, a2.
  logic signed [COEF_W-1:0] coef [N_STAGES][5];
  logic signed [DATA_W-1:0] x1 [N_STAGES];
  logic signed [DATA_W-1:0] x2 [N_STAGES];
  logic signed [DATA_W-1:0] y1 [N_STAGES];
  logic signed [DATA_W-1:0] y2 [N_STAGES];

  logic signed [DATA_W-1:0] op;
  logic signed [COEF_W-1:0] cf;
  logic                     byp_next;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [RES_W-1:0]  res;
  logic                     ovf;
  logic [DATA_W-1:0]        y_wb;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    op       = '0;
    cf       = '0;
    byp_next = 1'b0;
    for (int s = 0; s < N_STAGES; s++) begin
      if (stage == 3'(s)) begin
        case (kidx)
          3'd0:    op = cur_x;
          3'd1:    op = x1[s];
          3'd2:    op = x2[s];
          3'd3:    op = y1[s];
          default: op = y2[s];
        endcase
        for (int k = 0; k < 5; k++) begin
          if (kidx == 3'(k)) cf = coef[s][k];
        end
      end
      if (stage + 3'd1 == 3'(s)) byp_next = bypass[s];
    end
  end

  assign prod     = op * cf;
  assign prod_ext = ACC_W'(prod);
  // Feedback terms a1, a2 are subtracted.
  assign acc_next = (kidx >= 3'd3) ? acc - prod_ext : acc + prod_ext;

  assign acc_rnd  = acc + $signed(RND);
  assign acc_sh   = acc_rnd >>> FRAC_W;
  assign res      = acc_sh[RES_W-1:0];
  assign ovf      = !((&res[RES_W-1:DATA_W-1]) || !(|res[RES_W-1:DATA_W-1]));
  assign y_wb     = ovf ? (res[RES_W-1] ? Y_MIN : Y_MAX) : res[DATA_W-1:0];

  // Wishbone decode
  logic [31:0] off;
  logic [2:0]  a_s;
  logic [2:0]  a_k;
  logic        in_map;
  logic        is_coef;
  logic        is_ctrl;
  logic        is_stat;
  logic        wb_req;
  logic        wb_stall;
  logic        wb_take;
  logic        wb_write;
  logic [31:0] rdata;

  assign off      = wbs_adr_i - BASE_ADR;
  assign a_s      = off[7:5];
  assign a_k      = off[4:2];
  assign in_map   = (off[31:9] == 23'd0);
  assign is_coef  = in_map && !off[8] && (int'(a_s) < N_STAGES) && (a_k < 3'd5);
  assign is_ctrl  = in_map && (off[8:2] == 7'h40);
  assign is_stat  = in_map && (off[8:2] == 7'h41);

  assign wb_req   = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  // Writes that would disturb a sample in flight wait until the FSM is idle.
  assign wb_stall = wbs_we_i && (state != S_IDLE) && (is_coef || (is_ctrl && wbs_dat_i[1]));
  assign wb_take  = wb_req && !wb_stall;
  assign wb_write = wb_take && wbs_we_i && (wbs_sel_i == 4'hF);

  always_comb begin
    rdata = '0;
    if (is_ctrl) begin
      rdata = 32'({bypass, 7'd0, enable});
    end else if (is_stat) begin
      rdata = {30'd0, sat_o, busy_o};
    end else if (is_coef) begin
      for (int s = 0; s < N_STAGES; s++) begin
        for (int k = 0; k < 5; k++) begin
          if (a_s == 3'(s) && a_k == 3'(k)) rdata = 32'(coef[s][k]);
        end
      end
    end
  end

  assign ready_o = (state == S_IDLE) && enable;
  assign busy_o  = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      stage     <= '0;
      kidx      <= '0;
      stage_byp <= 1'b0;
      cur_x     <= '0;
      acc       <= '0;
      enable    <= 1'b0;
      bypass    <= '0;
      sat_o     <= 1'b0;
      y_o       <= '0;
      valid_o   <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      // NOTE: the coefficient and delay-line arrays are deliberately reset; a reset must return the filter to a known identity state.
      for (int s = 0; s < N_STAGES; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
        for (int k = 0; k < 5; k++) begin
          coef[s][k] <= (k == 0) ? COEF_ONE : '0;
        end
      end
    end else begin
      valid_o   <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;

      if (wb_take) begin
        wbs_ack_o <= 1'b1;
        wbs_dat_o <= wbs_we_i ? 32'd0 : rdata;
      end

      if (wb_write) begin
        for (int s = 0; s < N_STAGES; s++) begin
          for (int k = 0; k < 5; k++) begin
            if (is_coef && a_s == 3'(s) && a_k == 3'(k)) coef[s][k] <= wbs_dat_i[COEF_W-1:0];
          end
        end
        if (is_ctrl) begin
          enable <= wbs_dat_i[0];
          bypass <= wbs_dat_i[8 +: N_STAGES];
          if (wbs_dat_i[1]) begin
            for (int s = 0; s < N_STAGES; s++) begin
              x1[s] <= '0;
              x2[s] <= '0;
              y1[s] <= '0;
              y2[s] <= '0;
            end
          end
        end
        if (is_stat && wbs_dat_i[1]) sat_o <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (valid_i && ready_o) begin
            cur_x     <= x_i;
            stage     <= '0;
            kidx      <= '0;
            acc       <= '0;
            stage_byp <= bypass[0];
            state     <= bypass[0] ? S_WB : S_MAC;
          end
        end

        S_MAC: begin
          acc <= acc_next;
          if (kidx == 3'd4) state <= S_WB;
          else              kidx  <= kidx + 3'd1;
        end

        S_WB: begin
          if (!stage_byp) begin
            for (int s = 0; s < N_STAGES; s++) begin
              if (stage == 3'(s)) begin
                x2[s] <= x1[s];
                x1[s] <= cur_x;
                y2[s] <= y1[s];
                y1[s] <= y_wb;
              end
            end
            cur_x <= y_wb;
            if (ovf) sat_o <= 1'b1;
          end
          if (stage == LAST_STAGE) begin
            state <= S_OUT;
          end else begin
            stage     <= stage + 3'd1;
            kidx      <= '0;
            acc       <= '0;
            stage_byp <= byp_next;
            state     <= byp_next ? S_WB : S_MAC;
          end
        end

        S_OUT: begin
          y_o     <= cur_x;
          valid_o <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused;
  assign unused = ^{off[1:0], wbs_dat_i, acc_sh};

endmodule
